// File: rtl/uart_rx_stream_fifo.sv
// uart_rx_stream_fifo
//   Drains completed bytes from the UART decoder over its ready/release
//   handshake into a circular FIFO and presents them in order to a consumer
//   over a first-word-fall-through valid/take interface. Release is withheld
//   while the FIFO is full, which holds the byte in the decoder.
//
// Ports
//   i_Clk         system clock, rising edge
//   i_Reset       synchronous active-high reset
//   i_Dec_Byte    decoder byte, valid while i_Dec_Ready is high
//   i_Dec_Ready   decoder has a byte, held until released
//   o_Dec_Release single-cycle release pulse back to the decoder
//   o_Byte        head-of-FIFO byte, zero when empty
//   o_Valid       FIFO non-empty
//   i_Take        consumer pops the head when o_Valid is high
//   o_Count       occupancy, 0..DEPTH
//   o_Stall       decoder byte pending while the FIFO is full
module uart_rx_stream_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic [WIDTH-1:0]           i_Dec_Byte,
  input  logic                       i_Dec_Ready,
  output logic                       o_Dec_Release,
  output logic [WIDTH-1:0]           o_Byte,
  output logic                       o_Valid,
  input  logic                       i_Take,
  output logic [$clog2(DEPTH):0]     o_Count,
  output logic                       o_Stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               release_q, release_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic full;
  logic valid;
  logic wr_en;
  logic pop;

  // Full is judged on the registered count only, so a same-cycle pop
  // never opens space for a same-cycle write.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign valid = (count_q != '0);
  assign pop   = i_Take & valid;

  always_comb begin
    state_d   = state_q;
    release_d = 1'b0;
    wr_en     = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    case (state_q)
      S_IDLE: begin
        if (i_Dec_Ready && !full) begin
          wr_en     = 1'b1;
          release_d = 1'b1;
          state_d   = S_WAIT_DROP;
        end
      end
      // Ready stays high for a cycle or more after release; wait for it
      // to drop so the same byte is not captured twice.
      S_WAIT_DROP: begin
        if (!i_Dec_Ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      release_q <= release_d;
    end
  end

  // Storage is not reset; stale entries are never visible because o_Byte
  // is masked while empty.
  always_ff @(posedge i_Clk) begin
    if (wr_en && !i_Reset) begin
      mem_q[wr_ptr_q] <= i_Dec_Byte;
    end
  end

  assign o_Dec_Release = release_q;
  assign o_Valid       = valid;
  assign o_Byte        = valid ? mem_q[rd_ptr_q] : '0;
  assign o_Count       = count_q;
  assign o_Stall       = (state_q == S_IDLE) & i_Dec_Ready & full;

endmodule
